vco_nco: RTL and testbench

Parametrised numerically controlled oscillator: the next generation of the VCO block. A phase accumulator advances by a frequency tuning word (FTW). The FTW is derived from a signed control input around a programmable centre frequency. A slew limiter and a valid/ready handshake govern FTW updates. Output is a selectable waveform (saw, square, triangle, inverted saw) with a registered wrap pulse. It sits between the loop filter / control logic and any downstream DSP or DAC path.

---
 rtl/vco_nco.sv | 130 +++++++++++++
 tb/tb_vco_nco.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vco_nco.sv
// Numerically controlled oscillator: phase accumulator driven by a slew-limited
// tuning word, with selectable saw/square/triangle/inverted-saw output.
module vco_nco #(
  parameter int               ACC_W      = 24,
  parameter int               CTRL_W     = 16,
  parameter int               OUT_W      = 8,
  parameter logic [ACC_W-1:0] CENTER_FTW = 24'h010000,
  parameter int               GAIN_SHIFT = 0,
  parameter logic [ACC_W-1:0] SLEW       = '0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic [1:0]        i_mode,
  input  logic              i_phase_sync,
  input  logic              i_ctrl_valid,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_ctrl_ready,
  output logic [OUT_W-1:0]  o_data,
  output logic              o_valid,
  output logic              o_wrap
);

  // Handshake: a control word transfers on a rising edge where
  // i_ctrl_valid && o_ctrl_ready; o_ctrl_ready is high only while the tuning
  // word has settled on its target, and words offered while low are dropped.

  localparam int SUM_W = ACC_W + CTRL_W + GAIN_SHIFT + 1;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_ftw;
  logic [ACC_W-1:0] r_target;
  logic [OUT_W-1:0] r_data;
  logic             r_valid;
  logic             r_wrap;

  logic signed [SUM_W-1:0] w_ctrl_ext;
  logic signed [SUM_W-1:0] w_ctrl_sh;
  logic signed [SUM_W-1:0] w_center_ext;
  logic signed [SUM_W-1:0] w_sum;
  logic [ACC_W-1:0]        w_target_sat;
  logic                    w_ready;
  logic                    w_up;
  logic [ACC_W-1:0]        w_delta;
  logic                    w_slew_hit;
  logic [ACC_W:0]          w_acc_sum;
  logic [OUT_W-1:0]        w_saw;
  logic [OUT_W-1:0]        w_tri_bits;
  logic [OUT_W-1:0]        w_wave;

  assign w_ctrl_ext   = {{(SUM_W-CTRL_W){i_ctrl[CTRL_W-1]}}, i_ctrl};
  assign w_ctrl_sh    = w_ctrl_ext <<< GAIN_SHIFT;
  assign w_center_ext = {{(SUM_W-ACC_W){1'b0}}, CENTER_FTW};
  assign w_sum        = w_center_ext + w_ctrl_sh;

  // Clamp to [0, Nyquist): negative sums go to zero, anything with a bit set
  // at or above ACC_W-1 goes to the largest sub-Nyquist word.
  always_comb begin
    w_target_sat = '0;
    if (w_sum[SUM_W-1]) begin
      w_target_sat = '0;
    end else if (|w_sum[SUM_W-2:ACC_W-1]) begin
      w_target_sat = {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      w_target_sat = w_sum[ACC_W-1:0];
    end
  end

  assign w_ready    = (r_ftw == r_target);
  assign w_up       = (r_target > r_ftw);
  assign w_delta    = w_up ? (r_target - r_ftw) : (r_ftw - r_target);
  assign w_slew_hit = (SLEW == '0) || (w_delta <= SLEW);

  assign w_acc_sum  = {1'b0, r_acc} + {1'b0, r_ftw};

  assign w_saw      = r_acc[ACC_W-1 -: OUT_W];
  assign w_tri_bits = r_acc[ACC_W-2 -: OUT_W];

  always_comb begin
    w_wave = '0;
    case (i_mode)
      2'd0:    w_wave = w_saw;
      2'd1:    w_wave = {OUT_W{~r_acc[ACC_W-1]}};
      2'd2:    w_wave = r_acc[ACC_W-1] ? ~w_tri_bits : w_tri_bits;
      default: w_wave = ~w_saw;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_acc    <= '0;
      r_ftw    <= CENTER_FTW;
      r_target <= CENTER_FTW;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      if (i_ctrl_valid && w_ready) begin
        r_target <= w_target_sat;
      end

      // Slew runs every cycle, independent of i_enable.
      if (w_slew_hit) begin
        r_ftw <= r_target;
      end else if (w_up) begin
        r_ftw <= r_ftw + SLEW;
      end else begin
        r_ftw <= r_ftw - SLEW;
      end

      if (i_phase_sync) begin
        r_acc <= '0;
      end else if (i_enable) begin
        r_acc <= w_acc_sum[ACC_W-1:0];
      end

      r_wrap  <= i_enable && !i_phase_sync && w_acc_sum[ACC_W];
      r_valid <= i_enable;
      if (i_enable) begin
        r_data <= w_wave;
      end
    end
  end

  assign o_ctrl_ready = w_ready;
  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_wrap       = r_wrap;

endmodule

// File: tb/tb_vco_nco.sv
// Directed bench for vco_nco: free-run, slew ramp, saturation, sync/hold,
// waveform modes and asynchronous reset in the middle of a ramp.
module tb_vco_nco;

  localparam int               ACC_W      = 16;
  localparam int               CTRL_W     = 8;
  localparam int               OUT_W      = 8;
  localparam logic [ACC_W-1:0] CENTER_FTW = 16'h0100;
  localparam int               GAIN_SHIFT = 4;
  localparam logic [ACC_W-1:0] SLEW       = 16'h0040;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              sync = 1'b0;
  logic              cv = 1'b0;
  logic [CTRL_W-1:0] ctrl = '0;
  logic              ready;
  logic [OUT_W-1:0]  data;
  logic              valid;
  logic              wrap;

  int errors = 0;
  int checks = 0;

  // Bench reference model state
  logic [ACC_W-1:0] m_acc;
  logic [ACC_W-1:0] m_ftw;
  logic [OUT_W-1:0] m_data;
  logic             m_wrap;

  logic [ACC_W-1:0] ftw_tab [14] = '{16'h0100, 16'h0140, 16'h0180, 16'h01C0,
                                     16'h0200, 16'h0200, 16'h01C0, 16'h0180,
                                     16'h0140, 16'h0100, 16'h00C0, 16'h0080,
                                     16'h0040, 16'h0000};
  logic [OUT_W-1:0] mode_exp [4] = '{8'hC0, 8'h00, 8'h7F, 8'h3F};

  vco_nco #(
    .ACC_W(ACC_W), .CTRL_W(CTRL_W), .OUT_W(OUT_W), .CENTER_FTW(CENTER_FTW),
    .GAIN_SHIFT(GAIN_SHIFT), .SLEW(SLEW)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_mode(mode),
    .i_phase_sync(sync), .i_ctrl_valid(cv), .i_ctrl(ctrl),
    .o_ctrl_ready(ready), .o_data(data), .o_valid(valid), .o_wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; cv = 1'b0; ctrl = '0; mode = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (dut.r_ftw !== 16'h0100) begin errors++; $display("FAIL reset_ftw: got %h want 0100", dut.r_ftw); end
    checks++; if (dut.r_target !== 16'h0100) begin errors++; $display("FAIL reset_target: got %h want 0100", dut.r_target); end
    checks++; if (dut.r_acc !== 16'h0000) begin errors++; $display("FAIL reset_acc: got %h want 0000", dut.r_acc); end
  endtask

  task automatic test_free_run;
    int wraps;
    logic [OUT_W-1:0] exp_d;
    logic exp_w;
    wraps = 0;
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      exp_d = 8'(i - 1);
      exp_w = ((i % 256) == 0);
      checks++; if (data !== exp_d) begin errors++; $display("FAIL free_data[%0d]: got %h want %h", i, data, exp_d); end
      checks++; if (wrap !== exp_w) begin errors++; $display("FAIL free_wrap[%0d]: got %b want %b", i, wrap, exp_w); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL free_ready[%0d]: got %b want 1", i, ready); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL free_valid[%0d]: got %b want 1", i, valid); end
      if (wrap === 1'b1) wraps++;
    end
    checks++; if (wraps != 2) begin errors++; $display("FAIL free_wrap_count: got %0d want 2", wraps); end
  endtask

  // Ramp up to 0x0200 with a rejected offer while busy, then saturate to 0.
  task automatic test_ramp_saturate;
    logic [ACC_W-1:0] exp_tgt;
    logic exp_rdy;
    do_reset();
    en = 1'b1; ctrl = 8'h10; cv = 1'b1;
    m_acc = '0; m_ftw = 16'h0100; m_data = '0; m_wrap = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      m_data = m_acc[ACC_W-1 -: OUT_W];
      {m_wrap, m_acc} = {1'b0, m_acc} + {1'b0, m_ftw};
      m_ftw = (k <= 14) ? ftw_tab[k-1] : 16'h0000;
      exp_tgt = (k <= 5) ? 16'h0200 : 16'h0000;
      exp_rdy = (k == 5) || (k >= 14);
      checks++; if (dut.r_ftw !== m_ftw) begin errors++; $display("FAIL ramp_ftw[%0d]: got %h want %h", k, dut.r_ftw, m_ftw); end
      checks++; if (dut.r_target !== exp_tgt) begin errors++; $display("FAIL ramp_target[%0d]: got %h want %h", k, dut.r_target, exp_tgt); end
      checks++; if (ready !== exp_rdy) begin errors++; $display("FAIL ramp_ready[%0d]: got %b want %b", k, ready, exp_rdy); end
      checks++; if (dut.r_acc !== m_acc) begin errors++; $display("FAIL ramp_acc[%0d]: got %h want %h", k, dut.r_acc, m_acc); end
      checks++; if (data !== m_data) begin errors++; $display("FAIL ramp_data[%0d]: got %h want %h", k, data, m_data); end
      checks++; if (wrap !== m_wrap) begin errors++; $display("FAIL ramp_wrap[%0d]: got %b want %b", k, wrap, m_wrap); end
      if (k == 1) ctrl = 8'h7F;
      if (k == 5) ctrl = 8'h80;
      if (k == 6) cv = 1'b0;
    end
  endtask

  task automatic test_sync_hold;
    do_reset();
    en = 1'b1;
    repeat (255) @(negedge clk);
    checks++; if (dut.r_acc !== 16'hFF00) begin errors++; $display("FAIL sync_pre_acc: got %h want ff00", dut.r_acc); end
    sync = 1'b1;
    @(negedge clk);
    checks++; if (dut.r_acc !== 16'h0000) begin errors++; $display("FAIL sync_acc: got %h want 0000", dut.r_acc); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL sync_wrap: got %b want 0", wrap); end
    checks++; if (data !== 8'hFF) begin errors++; $display("FAIL sync_data_prev: got %h want ff", data); end
    sync = 1'b0;
    @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL sync_data: got %h want 00", data); end
    checks++; if (dut.r_acc !== 16'h0100) begin errors++; $display("FAIL sync_acc_next: got %h want 0100", dut.r_acc); end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (dut.r_acc !== 16'h0100) begin errors++; $display("FAIL hold_acc[%0d]: got %h want 0100", i, dut.r_acc); end
      checks++; if (data !== 8'h00) begin errors++; $display("FAIL hold_data[%0d]: got %h want 00", i, data); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL hold_valid[%0d]: got %b want 0", i, valid); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL hold_wrap[%0d]: got %b want 0", i, wrap); end
    end
    en = 1'b1;
    @(negedge clk);
    checks++; if (dut.r_acc !== 16'h0200) begin errors++; $display("FAIL resume_acc: got %h want 0200", dut.r_acc); end
    checks++; if (data !== 8'h01) begin errors++; $display("FAIL resume_data: got %h want 01", data); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL resume_valid: got %b want 1", valid); end
    sync = 1'b1;
    @(negedge clk);
    checks++; if (dut.r_acc !== 16'h0000) begin errors++; $display("FAIL midsync_acc: got %h want 0000", dut.r_acc); end
    checks++; if (data !== 8'h02) begin errors++; $display("FAIL midsync_data_prev: got %h want 02", data); end
    sync = 1'b0;
    @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL midsync_data: got %h want 00", data); end
  endtask

  task automatic test_modes;
    for (int m = 0; m < 4; m++) begin
      do_reset();
      en = 1'b1;
      repeat (192) @(negedge clk);
      checks++; if (dut.r_acc !== 16'hC000) begin errors++; $display("FAIL mode%0d_acc: got %h want c000", m, dut.r_acc); end
      mode = 2'(m);
      @(negedge clk);
      checks++; if (data !== mode_exp[m]) begin errors++; $display("FAIL mode%0d_data: got %h want %h", m, data, mode_exp[m]); end
    end
  endtask

  task automatic test_reset_mid_ramp;
    do_reset();
    en = 1'b1;
    repeat (5) @(negedge clk);
    ctrl = 8'h10; cv = 1'b1;
    @(negedge clk);
    cv = 1'b0;
    checks++; if (dut.r_target !== 16'h0200) begin errors++; $display("FAIL mid_target: got %h want 0200", dut.r_target); end
    @(negedge clk);
    checks++; if (dut.r_ftw !== 16'h0140) begin errors++; $display("FAIL mid_ftw: got %h want 0140", dut.r_ftw); end
    checks++; if (data !== 8'h06) begin errors++; $display("FAIL mid_data: got %h want 06", data); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL arst_data: got %h want 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", valid); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL arst_wrap: got %b want 0", wrap); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b want 1", ready); end
    checks++; if (dut.r_ftw !== 16'h0100) begin errors++; $display("FAIL arst_ftw: got %h want 0100", dut.r_ftw); end
    checks++; if (dut.r_target !== 16'h0100) begin errors++; $display("FAIL arst_target: got %h want 0100", dut.r_target); end
    checks++; if (dut.r_acc !== 16'h0000) begin errors++; $display("FAIL arst_acc: got %h want 0000", dut.r_acc); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (dut.r_ftw !== 16'h0100) begin errors++; $display("FAIL post_ftw[%0d]: got %h want 0100", i, dut.r_ftw); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL post_ready[%0d]: got %b want 1", i, ready); end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_ramp_saturate();
    test_sync_hold();
    test_modes();
    test_reset_mid_ramp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
